// File: rtl/centroid_overlay.sv
// rtl/centroid_overlay.sv - green-threshold mask, frame centroid and crosshair overlay
//
// Thresholds the green field of each valid pixel into a mask. Masked
// coordinates are summed over a frame; at frame_done_in the sums are divided
// by the pixel count with a serial restoring divider to produce the centroid.
// Mask, delayed pixel and crosshair hit leave together one cycle after input.
//
// Optional feature macro: CROSSHAIR_EN (crosshair_out is tied to 0 when undefined).
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   hcount_in, vcount_in  pixel column (0..1279) / row (0..719)
//   pixel_in, valid_in    RGB444 pixel and its qualifier
//   frame_done_in         single-cycle end-of-frame pulse
//   thresh_in             green threshold (mask when green >= thresh)
//   data_out, mask_out, crosshair_out   aligned, 1-cycle latency video outputs
//   x_out, y_out          latest centroid
//   centroid_valid_out    pulses when x_out/y_out update
//   busy_out              divider FSM not IDLE
//   overrun_out           pulses when a frame_done_in is dropped
module centroid_overlay #(
  parameter int THRESH_W = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [10:0]         hcount_in,
  input  logic [9:0]          vcount_in,
  input  logic [11:0]         pixel_in,
  input  logic                valid_in,
  input  logic                frame_done_in,
  input  logic [THRESH_W-1:0] thresh_in,
  output logic [11:0]         data_out,
  output logic                mask_out,
  output logic                crosshair_out,
  output logic [10:0]         x_out,
  output logic [9:0]          y_out,
  output logic                centroid_valid_out,
  output logic                busy_out,
  output logic                overrun_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_DIV_X, ST_DIV_Y, ST_DONE} state_t;

  localparam int CW = (THRESH_W > 4) ? THRESH_W : 4;

  state_t      state_q;
  logic        start_q;      // snapshot taken, DIV_X begins next cycle
  logic [31:0] x_sum_q, y_sum_q;
  logic [19:0] count_q;
  logic [31:0] rem_q, quo_q, y_op_q;
  logic [19:0] div_q;
  logic [10:0] qx_q;
  logic [4:0]  step_q;
  logic [11:0] data_q;
  logic        mask_q, hit_q, cvalid_q, overrun_q;
  logic [10:0] x_q;
  logic [9:0]  y_q;

  logic        mask_d, hit_d, busy_d;
  logic [CW-1:0] green_ext, thresh_ext;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] rem_d, quo_d;

  assign green_ext  = CW'(pixel_in[7:4]);
  assign thresh_ext = CW'(thresh_in);
  assign mask_d     = valid_in && (green_ext >= thresh_ext);

`ifdef CROSSHAIR_EN
  assign hit_d = valid_in && ((hcount_in == x_q) || (vcount_in == y_q));
`else
  assign hit_d = 1'b0;
`endif

  // The snapshot cycle counts as busy so a second frame_done there is an overrun.
  assign busy_d = (state_q != ST_IDLE) || start_q;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign rem_sh = {rem_q, quo_q[31]};
  assign ge     = rem_sh >= {13'd0, div_q};
  assign rem_d  = ge ? 32'(rem_sh - {13'd0, div_q}) : rem_sh[31:0];
  assign quo_d  = {quo_q[30:0], ge};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      x_sum_q   <= '0;
      y_sum_q   <= '0;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      y_op_q    <= '0;
      div_q     <= '0;
      qx_q      <= '0;
      step_q    <= '0;
      data_q    <= '0;
      mask_q    <= 1'b0;
      hit_q     <= 1'b0;
      cvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      data_q    <= pixel_in;
      mask_q    <= mask_d;
      hit_q     <= hit_d;
      cvalid_q  <= 1'b0;
      overrun_q <= 1'b0;

      // A pixel coinciding with frame_done belongs to the new frame.
      if (frame_done_in) begin
        x_sum_q <= mask_d ? 32'(hcount_in) : 32'd0;
        y_sum_q <= mask_d ? 32'(vcount_in) : 32'd0;
        count_q <= mask_d ? 20'd1 : 20'd0;
        if (busy_d) begin
          overrun_q <= 1'b1;
        end else if (count_q != 20'd0) begin
          quo_q   <= x_sum_q;
          y_op_q  <= y_sum_q;
          div_q   <= count_q;
          rem_q   <= '0;
          start_q <= 1'b1;
        end
      end else if (mask_d) begin
        x_sum_q <= x_sum_q + 32'(hcount_in);
        y_sum_q <= y_sum_q + 32'(vcount_in);
        count_q <= count_q + 20'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_q) begin
            start_q <= 1'b0;
            step_q  <= '0;
            state_q <= ST_DIV_X;
          end
        end
        ST_DIV_X: begin
          step_q <= step_q + 5'd1;
          if (step_q == 5'd31) begin
            qx_q    <= quo_d[10:0];
            quo_q   <= y_op_q;
            rem_q   <= '0;
            state_q <= ST_DIV_Y;
          end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
          end
        end
        ST_DIV_Y: begin
          step_q <= step_q + 5'd1;
          quo_q  <= quo_d;
          rem_q  <= rem_d;
          if (step_q == 5'd31) state_q <= ST_DONE;
        end
        default: begin
          x_q      <= qx_q;
          y_q      <= quo_q[9:0];
          cvalid_q <= 1'b1;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out           = data_q;
  assign mask_out           = mask_q;
  assign crosshair_out      = hit_q;
  assign x_out              = x_q;
  assign y_out              = y_q;
  assign centroid_valid_out = cvalid_q;
  assign busy_out           = (state_q != ST_IDLE);
  assign overrun_out        = overrun_q;

endmodule

// File: tb/tb_centroid_overlay.sv
// tb/tb_centroid_overlay.sv - randomized and directed bench for centroid_overlay against a frame-level model
module tb_centroid_overlay;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [11:0] pixel = '0;
  logic        valid = 1'b0;
  logic        fd = 1'b0;
  logic [3:0]  thresh = 4'd4;
  logic [11:0] data_out;
  logic        mask_out, crosshair_out, cvalid, busy, overrun;
  logic [10:0] x_out;
  logic [9:0]  y_out;

  centroid_overlay #(.THRESH_W(4)) dut (
    .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .pixel_in(pixel), .valid_in(valid), .frame_done_in(fd), .thresh_in(thresh),
    .data_out(data_out), .mask_out(mask_out), .crosshair_out(crosshair_out),
    .x_out(x_out), .y_out(y_out), .centroid_valid_out(cvalid),
    .busy_out(busy), .overrun_out(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level reference state
  int          cyc = 0;
  longint      sx = 0, sy = 0, n = 0;
  int          ex = 0, ey = 0;
  bit          have_pend = 0;
  int          pend_x = 0, pend_y = 0, due = 0;
  int          busy_from = 1, busy_until = -1;
  int          pulses = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sx = 0; sy = 0; n = 0; ex = 0; ey = 0;
    have_pend = 0; busy_from = 1; busy_until = -1;
  endtask

  task automatic step(input logic v, input logic [10:0] h, input logic [9:0] vc,
                      input logic [11:0] p, input logic f);
    bit m, cr, ov, ev, eb;
    logic [11:0] ed;
    @(negedge clk);
    valid = v; hcount = h; vcount = vc; pixel = p; fd = f;
    @(posedge clk);
    cyc++;
    m = 0; cr = 0; ov = 0; ev = 0; eb = 0; ed = '0;
    if (!rst) begin
      ed = p;
      m  = v && (p[7:4] >= thresh);
`ifdef CROSSHAIR_EN
      cr = v && ((int'(h) == ex) || (int'(vc) == ey));
`endif
      if (f) begin
        if (cyc <= busy_until) ov = 1;
        else if (n > 0) begin
          pend_x = int'((sx / n) % 2048);
          pend_y = int'((sy / n) % 1024);
          due = cyc + 66; have_pend = 1;
          busy_from = cyc + 1; busy_until = cyc + 66;
        end
        sx = 0; sy = 0; n = 0;
      end
      if (m) begin sx += h; sy += vc; n++; end
      if (have_pend && due == cyc) begin
        ev = 1; ex = pend_x; ey = pend_y; have_pend = 0;
      end
      eb = (cyc >= busy_from) && (cyc < busy_until);
    end
    #1;
    if (cvalid) pulses++;
    check_eq("data_out", 32'(data_out), 32'(ed));
    check_eq("mask_out", 32'(mask_out), 32'(m));
    check_eq("crosshair_out", 32'(crosshair_out), 32'(cr));
    check_eq("centroid_valid", 32'(cvalid), 32'(ev));
    check_eq("overrun_out", 32'(overrun), 32'(ov));
    check_eq("busy_out", 32'(busy), 32'(eb));
    check_eq("x_out", 32'(x_out), 32'(ex));
    check_eq("y_out", 32'(y_out), 32'(ey));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, '0, '0, '0, 0);
  endtask

  initial begin
    int p0, np;
    // Reset state
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Single masked pixel (100,50), green 5 vs thresh 4
    thresh = 4'd4;
    pulses = 0;
    step(1, 11'd100, 10'd50, 12'h050, 0);
    step(0, '0, '0, '0, 1);
    idle(70);
    check_eq("single_x", 32'(x_out), 32'd100);
    check_eq("single_y", 32'(y_out), 32'd50);
    check_eq("single_pulses", 32'(pulses), 32'd1);

    // Two pixels, truncating average
    step(1, 11'd10, 10'd20, 12'hF8F, 0);
    step(1, 11'd13, 10'd25, 12'h040, 0);
    step(0, '0, '0, '0, 1);
    idle(70);
    check_eq("pair_x", 32'(x_out), 32'd11);
    check_eq("pair_y", 32'(y_out), 32'd22);

    // Nothing passes the threshold: no result, stays idle
    pulses = 0;
    step(1, 11'd500, 10'd300, 12'hF3F, 0);
    step(1, 11'd600, 10'd400, 12'h000, 0);
    step(0, '0, '0, '0, 1);
    idle(70);
    check_eq("empty_pulses", 32'(pulses), 32'd0);
    check_eq("empty_x", 32'(x_out), 32'd11);

    // Second frame_done 10 cycles after the first
    pulses = 0;
    step(1, 11'd100, 10'd50, 12'h050, 0);
    step(0, '0, '0, '0, 1);
    idle(9);
    step(1, 11'd7, 10'd9, 12'h0F0, 1);
    idle(70);
    check_eq("overrun_pulses", 32'(pulses), 32'd1);
    check_eq("overrun_x", 32'(x_out), 32'd100);

    // Crosshair against (100,50); green 0 keeps these out of the accumulators
    step(1, 11'd100, 10'd7, 12'h000, 0);
    step(1, 11'd3, 10'd50, 12'h000, 0);
    step(1, 11'd3, 10'd7, 12'h000, 0);
    idle(2);

    // Random frames, sometimes overlapping a division in progress
    for (int fr = 0; fr < 8; fr++) begin
      thresh = 4'($urandom_range(0, 15));
      np = $urandom_range(0, 40);
      for (int i = 0; i < np; i++) begin
        p0 = $urandom_range(0, 3);
        step(p0 != 0, 11'($urandom_range(0, 1279)), 10'($urandom_range(0, 719)),
             12'($urandom), 0);
      end
      step($urandom_range(0, 1) == 1, 11'($urandom_range(0, 1279)),
           10'($urandom_range(0, 719)), 12'($urandom), 1);
      idle($urandom_range(40, 80));
    end
    idle(70);

    // Reset during DIV_X aborts the division
    thresh = 4'd4;
    pulses = 0;
    step(1, 11'd200, 10'd100, 12'h0F0, 0);
    step(0, '0, '0, '0, 1);
    idle(31);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_data", 32'(data_out), 32'd0);
    check_eq("arst_x", 32'(x_out), 32'd0);
    check_eq("arst_y", 32'(y_out), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_valid", 32'(cvalid), 32'd0);
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(80);
    check_eq("arst_pulses", 32'(pulses), 32'd0);

    // Fresh result after reset
    step(1, 11'd640, 10'd360, 12'h0A0, 0);
    step(0, '0, '0, '0, 1);
    idle(70);
    check_eq("post_rst_x", 32'(x_out), 32'd640);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
